fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 20, instruction width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, instruction address width (256 words).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: hazard hold request from the downstream datapath.
REQ-006 The block SHALL have port redirect, input, 1 bit: taken branch or JMP resolved downstream.
REQ-007 The block SHALL have port redirect_target, input, ADDRESS_WIDTH bits: new PC when redirect is high.
REQ-008 The block SHALL have port halt_req, input, 1 bit: stop fetching permanently until reset.
REQ-009 The block SHALL have port imem_addr, output, ADDRESS_WIDTH bits: combinational copy of the PC register.
REQ-010 The block SHALL have port imem_data, input, DATA_WIDTH bits: combinational instruction ROM read of imem_addr.
REQ-011 The block SHALL have port if_id_instruction, output, DATA_WIDTH bits: registered instruction to decode.
REQ-012 The block SHALL have port if_id_pc, output, ADDRESS_WIDTH bits: PC of if_id_instruction.
REQ-013 The block SHALL have port if_id_valid, output, 1 bit: if_id_instruction is real, not a bubble.
REQ-014 The block SHALL have port halted, output, 1 bit: high while in state HALT.
REQ-015 The block SHALL have ports fetch_count and bubble_count, outputs, 16 bits each: statistics counters (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HALT; IDLE is the reset state.
REQ-017 IDLE SHALL go to FETCH unconditionally on the first clock edge after reset release, with no PC or IF/ID update.
REQ-018 In FETCH, the edge priority SHALL be halt_req > redirect > stall > normal advance.
REQ-019 On normal advance: if_id_instruction <= imem_data, if_id_pc <= PC, if_id_valid <= 1, PC <= PC+1.
REQ-020 PC increment SHALL be modulo 2^ADDRESS_WIDTH (255 -> 0), with no flag.
REQ-021 On redirect: PC <= redirect_target; if_id_instruction <= 0; if_id_valid <= 0 (flush), regardless of stall.
REQ-022 On stall without redirect or halt_req: PC, if_id_instruction, if_id_pc and if_id_valid SHALL hold.
REQ-023 On halt_req: go to HALT; PC holds; if_id_instruction <= 0; if_id_valid <= 0; a simultaneous redirect is ignored.
REQ-024 HALT SHALL be left only by reset; all inputs are ignored there; halted = 1.
REQ-025 halt_req, redirect and stall SHALL be ignored in IDLE.
REQ-026 Redirect-to-valid latency SHALL be 2 edges: the flush edge, then the edge that captures the target instruction.

Reset
REQ-027 Asserting rst SHALL immediately set PC = 0, state = IDLE, if_id_instruction = 0, if_id_pc = 0, if_id_valid = 0, halted = 0, fetch_count = 0 and bubble_count = 0.
REQ-028 Reset asserted mid-operation, including in HALT or during stall, SHALL discard all state with no partial update.

Configuration
REQ-029 Macro FETCH_STATS_EN SHALL control the statistics counters.
REQ-030 With FETCH_STATS_EN defined: fetch_count SHALL increment on each normal-advance edge; bubble_count SHALL increment on each FETCH-state edge that is a stall, redirect or halt_req; both saturate at 16'hFFFF.
REQ-031 Without FETCH_STATS_EN: both counter ports SHALL exist and be tied to 0, with no counter registers.

Verification
REQ-032 Release rst with imem word at address k = 20'h00100+k, no stall -> if_id_valid first high on edge 2 with if_id_pc=0, if_id_instruction=20'h00100; then pc 1, 2, 3 on consecutive edges.
REQ-033 Stall for 3 cycles while if_id_pc=5 -> IF/ID and imem_addr hold at 5/6 for 3 edges, then resume with if_id_pc=6.
REQ-034 redirect=1, redirect_target=8'h40, with stall=1 in the same cycle -> next edge if_id_valid=0 and imem_addr=8'h40; the following edge if_id_pc=8'h40, valid=1.
REQ-035 Run from redirect_target=8'hFE -> if_id_pc sequence FE, FF, 00, 01.
REQ-036 halt_req=1 and redirect=1 in the same cycle -> halted=1, if_id_valid=0, imem_addr unchanged; later redirect/stall have no effect; rst returns PC to 0 and the block to IDLE.
REQ-037 With FETCH_STATS_EN: 10 advances, 2 stall cycles and 1 redirect -> fetch_count=10, bubble_count=3; without the macro both read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the program counter, drives it to the instruction ROM and captures
// the returned word into the IF/ID register. A three-state FSM sequences
// start-up (IDLE), normal operation (FETCH) and a permanent stop (HALT).
// In FETCH the edge priority is halt_req > redirect > stall > advance.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   stall             hold PC and IF/ID (hazard from downstream)
//   redirect          load PC from redirect_target and flush IF/ID
//   redirect_target   new PC on redirect
//   halt_req          enter HALT; only reset leaves it
//   imem_addr         ROM address (the PC register)
//   imem_data         ROM read data for imem_addr
//   if_id_instruction registered instruction to decode
//   if_id_pc          PC of if_id_instruction
//   if_id_valid       IF/ID holds a real instruction, not a bubble
//   halted            high while in HALT
//   fetch_count       saturating count of advance edges
//   bubble_count      saturating count of stall/redirect/halt edges in FETCH
//
// Build option: define FETCH_STATS_EN to implement the two statistics
// counters; otherwise both ports are tied to zero.

module fetch_stage #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     halt_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  output logic [DATA_WIDTH-1:0]    if_id_instruction,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc,
  output logic                     if_id_valid,
  output logic                     halted,
  output logic [15:0]              fetch_count,
  output logic [15:0]              bubble_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                     valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      id_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (halt_req) begin
          state_d = HALT;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (redirect) begin
          // Flush; the target word is captured on the following edge.
          pc_d    = redirect_target;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_data;
          id_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDRESS_WIDTH'(1);
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr         = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = id_pc_q;
  assign if_id_valid       = valid_q;
  assign halted            = (state_q == HALT);

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] bubble_count_q, bubble_count_d;
  logic        bubble_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    bubble_edge    = halt_req || redirect || stall;
    if (state_q == FETCH) begin
      if (bubble_edge) begin
        if (bubble_count_q != '1) bubble_count_d = bubble_count_q + 16'd1;
      end else begin
        if (fetch_count_q != '1) fetch_count_d = fetch_count_q + 16'd1;
      end
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  assign fetch_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_target;
  logic        halt_req;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] if_id_instruction;
  logic [7:0]  if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic [15:0] bubble_count;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt_req(halt_req),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .halted(halted),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  // ROM model: word k = 20'h00100 + k
  assign imem_data = 20'h00100 + {12'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; redirect = 1'b0; halt_req = 1'b0; redirect_target = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instruction, imem_addr, halted, fetch_count, bubble_count}
        !== {1'b0, 8'h00, 20'h00000, 8'h00, 1'b0, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got v=%b pc=%h ins=%h addr=%h h=%b fc=%0d bc=%0d, want all zero",
               if_id_valid, if_id_pc, if_id_instruction, imem_addr, halted, fetch_count, bubble_count);
    end
  endtask

  task automatic test_advance();
    rst = 1'b0;
    step(); // edge 1: IDLE -> FETCH
    checks++;
    if ({if_id_valid, imem_addr} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL idle_edge: got v=%b addr=%h, want v=0 addr=00", if_id_valid, imem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instruction, imem_addr}
          !== {1'b1, 8'(k), 20'h00100 + 20'(k), 8'(k + 1)}) begin
        errors++;
        $display("FAIL advance_%0d: got v=%b pc=%h ins=%h addr=%h, want v=1 pc=%h ins=%h addr=%h",
                 k, if_id_valid, if_id_pc, if_id_instruction, imem_addr,
                 8'(k), 20'h00100 + 20'(k), 8'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instruction, imem_addr} !== {1'b1, 8'h05, 20'h00105, 8'h06}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h addr=%h, want v=1 pc=05 ins=00105 addr=06",
                 i, if_id_valid, if_id_pc, if_id_instruction, imem_addr);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instruction, imem_addr} !== {1'b1, 8'h06, 20'h00106, 8'h07}) begin
      errors++;
      $display("FAIL stall_resume: got v=%b pc=%h ins=%h addr=%h, want v=1 pc=06 ins=00106 addr=07",
               if_id_valid, if_id_pc, if_id_instruction, imem_addr);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_target = 8'h40; stall = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({if_id_valid, if_id_instruction, imem_addr} !== {1'b0, 20'h00000, 8'h40}) begin
      errors++;
      $display("FAIL redirect_flush: got v=%b ins=%h addr=%h, want v=0 ins=00000 addr=40",
               if_id_valid, if_id_instruction, imem_addr);
    end
    step();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instruction} !== {1'b1, 8'h40, 20'h00140}) begin
      errors++;
      $display("FAIL redirect_target: got v=%b pc=%h ins=%h, want v=1 pc=40 ins=00140",
               if_id_valid, if_id_pc, if_id_instruction);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    redirect = 1'b1; redirect_target = 8'hFE;
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instruction}
          !== {1'b1, exp_pc[i], 20'h00100 + {12'd0, exp_pc[i]}}) begin
        errors++;
        $display("FAIL wrap_%0d: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h", i,
                 if_id_valid, if_id_pc, if_id_instruction, exp_pc[i], 20'h00100 + {12'd0, exp_pc[i]});
      end
    end
  endtask

  task automatic test_halt();
    // PC is 02 after the wrap test
    halt_req = 1'b1; redirect = 1'b1; redirect_target = 8'h20;
    step();
    clear_inputs();
    checks++;
    if ({halted, if_id_valid, if_id_instruction, imem_addr} !== {1'b1, 1'b0, 20'h00000, 8'h02}) begin
      errors++;
      $display("FAIL halt_enter: got h=%b v=%b ins=%h addr=%h, want h=1 v=0 ins=00000 addr=02",
               halted, if_id_valid, if_id_instruction, imem_addr);
    end
    redirect = 1'b1; redirect_target = 8'h33; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      stall = ~stall;
      checks++;
      if ({halted, if_id_valid, imem_addr} !== {1'b1, 1'b0, 8'h02}) begin
        errors++;
        $display("FAIL halt_sticky_%0d: got h=%b v=%b addr=%h, want h=1 v=0 addr=02",
                 i, halted, if_id_valid, imem_addr);
      end
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if ({halted, imem_addr, if_id_pc} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL halt_reset: got h=%b addr=%h pc=%h, want h=0 addr=00 pc=00",
               halted, imem_addr, if_id_pc);
    end
    step();
  endtask

  task automatic test_idle_ignore();
    rst = 1'b0;
    halt_req = 1'b1; redirect = 1'b1; redirect_target = 8'h55; stall = 1'b1;
    step(); // IDLE edge: everything ignored
    clear_inputs();
    checks++;
    if ({halted, if_id_valid, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL idle_ignore: got h=%b v=%b addr=%h, want h=0 v=0 addr=00",
               halted, if_id_valid, imem_addr);
    end
    step();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instruction} !== {1'b1, 8'h00, 20'h00100}) begin
      errors++;
      $display("FAIL idle_then_fetch: got v=%b pc=%h ins=%h, want v=1 pc=00 ins=00100",
               if_id_valid, if_id_pc, if_id_instruction);
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_fc, exp_bc;
`ifdef FETCH_STATS_EN
    exp_fc = 16'd10; exp_bc = 16'd3;
`else
    exp_fc = 16'd0;  exp_bc = 16'd0;
`endif
    clear_inputs();
    do_reset();
    step(); // IDLE
    for (int i = 0; i < 10; i++) step();
    stall = 1'b1;
    step();
    step();
    stall = 1'b0; redirect = 1'b1; redirect_target = 8'h10;
    step();
    clear_inputs();
    checks++;
    if ({fetch_count, bubble_count} !== {exp_fc, exp_bc}) begin
      errors++;
      $display("FAIL stats: got fc=%0d bc=%0d, want fc=%0d bc=%0d",
               fetch_count, bubble_count, exp_fc, exp_bc);
    end
    // asynchronous reset in the middle of a stall
    stall = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instruction, imem_addr, halted, fetch_count, bubble_count}
        !== {1'b0, 8'h00, 20'h00000, 8'h00, 1'b0, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_mid_stall: got v=%b pc=%h ins=%h addr=%h h=%b fc=%0d bc=%0d, want all zero",
               if_id_valid, if_id_pc, if_id_instruction, imem_addr, halted, fetch_count, bubble_count);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_advance();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_idle_ignore();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
